// File: rtl/huffman_pkg.sv
// Shared types and default sizes for the Huffman tree datapath.
package huffman_pkg;
    localparam int HUF_N  = 16;
    localparam int HUF_W  = 8;
    localparam int HUF_IW = $clog2(HUF_N);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, WAIT} state_t;

    typedef struct packed {
        logic              valid;
        logic [HUF_W-1:0]  weight;
    } node_t;
endpackage

// File: rtl/min2_track.sv
// Combinational best/second-smallest update for one candidate.
// Strict compares keep the earlier (lower-index) entry on ties.
module min2_track #(
    parameter int W  = 8,
    parameter int IW = 4
) (
    input  logic          best_vld_i,
    input  logic [W-1:0]  best_w_i,
    input  logic [IW-1:0] best_idx_i,
    input  logic          sec_vld_i,
    input  logic [W-1:0]  sec_w_i,
    input  logic [IW-1:0] sec_idx_i,
    input  logic          cand_vld_i,
    input  logic [W-1:0]  cand_w_i,
    input  logic [IW-1:0] cand_idx_i,
    output logic          best_vld_o,
    output logic [W-1:0]  best_w_o,
    output logic [IW-1:0] best_idx_o,
    output logic          sec_vld_o,
    output logic [W-1:0]  sec_w_o,
    output logic [IW-1:0] sec_idx_o
);
    always_comb begin
        best_vld_o = best_vld_i;
        best_w_o   = best_w_i;
        best_idx_o = best_idx_i;
        sec_vld_o  = sec_vld_i;
        sec_w_o    = sec_w_i;
        sec_idx_o  = sec_idx_i;
        if (cand_vld_i) begin
            if (!best_vld_i || cand_w_i < best_w_i) begin
                sec_vld_o  = best_vld_i;
                sec_w_o    = best_w_i;
                sec_idx_o  = best_idx_i;
                best_vld_o = 1'b1;
                best_w_o   = cand_w_i;
                best_idx_o = cand_idx_i;
            end else if (!sec_vld_i || cand_w_i < sec_w_i) begin
                sec_vld_o  = 1'b1;
                sec_w_o    = cand_w_i;
                sec_idx_o  = cand_idx_i;
            end
        end
    end
endmodule

// File: rtl/huffman_min2_select.sv
// Node-weight table with a serial min-2 scan; issues one pair per round
// to the adder and folds the merged sum back into the table.
module huffman_min2_select
    import huffman_pkg::*;
#(
    parameter int N  = HUF_N,
    parameter int W  = HUF_W,
    parameter int IW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          load_en,
    input  logic [IW-1:0] load_idx,
    input  logic [W-1:0]  load_weight,
    input  logic          clear,
    input  logic          start,
    output logic          busy,
    output logic [W-1:0]  ADD_1,
    output logic [W-1:0]  ADD_2,
    output logic [IW-1:0] idx1,
    output logic [IW-1:0] idx2,
    output logic          add_begin,
    input  logic          merge_we,
    input  logic [W-1:0]  merge_sum,
    output logic          last_node,
    output logic [IW:0]   active_cnt
);
    state_t        state_q, state_d;
    node_t         tbl_q [N];
    logic [IW-1:0] scan_idx_q;
    logic          best_vld_q, sec_vld_q, best_vld_d, sec_vld_d;
    logic [W-1:0]  best_w_q, sec_w_q, best_w_d, sec_w_d;
    logic [IW-1:0] best_idx_q, sec_idx_q, best_idx_d, sec_idx_d;
    logic [W-1:0]  add1_q, add2_q;
    logic [IW-1:0] idx1_q, idx2_q;
    logic          pair_q;
    logic [IW:0]   cnt_q, cnt_d;
    logic          load_ok, scan_last, do_load, do_merge;

    // Indices past N only exist when N is not a power of two.
    if ((2 ** IW) > N) begin : g_idx_chk
        assign load_ok = (int'(load_idx) < N);
    end else begin : g_idx_all
        assign load_ok = 1'b1;
    end

    assign scan_last = (state_q == SCAN) && (scan_idx_q == IW'(N - 1));
    assign do_load   = (state_q == IDLE) && load_en && load_ok;
    assign do_merge  = (state_q == WAIT) && merge_we;

    min2_track #(.W(W), .IW(IW)) u_track (
        .best_vld_i (best_vld_q),
        .best_w_i   (best_w_q),
        .best_idx_i (best_idx_q),
        .sec_vld_i  (sec_vld_q),
        .sec_w_i    (sec_w_q),
        .sec_idx_i  (sec_idx_q),
        .cand_vld_i (tbl_q[scan_idx_q].valid),
        .cand_w_i   (tbl_q[scan_idx_q].weight),
        .cand_idx_i (scan_idx_q),
        .best_vld_o (best_vld_d),
        .best_w_o   (best_w_d),
        .best_idx_o (best_idx_d),
        .sec_vld_o  (sec_vld_d),
        .sec_w_o    (sec_w_d),
        .sec_idx_o  (sec_idx_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (scan_last) state_d = EMIT;
            EMIT:    state_d = pair_q ? WAIT : IDLE;
            WAIT:    if (merge_we) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (clear) cnt_d = '0;
            // After a clear every slot counts as inactive again.
            if (do_load && (clear || !tbl_q[load_idx].valid)) cnt_d = cnt_d + 1'b1;
        end else if (do_merge) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Weights carry no reset; only the valid bits define table contents.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < N; i++) tbl_q[i].valid <= 1'b0;
        end else if (state_q == IDLE) begin
            if (clear) for (int i = 0; i < N; i++) tbl_q[i].valid <= 1'b0;
            if (do_load) begin
                tbl_q[load_idx].valid  <= 1'b1;
                tbl_q[load_idx].weight <= load_weight;
            end
        end else if (do_merge) begin
            tbl_q[idx1_q].weight <= merge_sum;
            tbl_q[idx2_q].valid  <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            scan_idx_q <= '0;
            best_vld_q <= 1'b0;
            sec_vld_q  <= 1'b0;
            best_w_q   <= '0;
            sec_w_q    <= '0;
            best_idx_q <= '0;
            sec_idx_q  <= '0;
            add1_q     <= '0;
            add2_q     <= '0;
            idx1_q     <= '0;
            idx2_q     <= '0;
            pair_q     <= 1'b0;
        end else if (state_q == IDLE && start) begin
            scan_idx_q <= '0;
            best_vld_q <= 1'b0;
            sec_vld_q  <= 1'b0;
        end else if (state_q == SCAN) begin
            scan_idx_q <= scan_idx_q + 1'b1;
            best_vld_q <= best_vld_d;
            best_w_q   <= best_w_d;
            best_idx_q <= best_idx_d;
            sec_vld_q  <= sec_vld_d;
            sec_w_q    <= sec_w_d;
            sec_idx_q  <= sec_idx_d;
            if (scan_last) begin
                pair_q <= sec_vld_d;
                if (sec_vld_d) begin
                    add1_q <= best_w_d;
                    add2_q <= sec_w_d;
                    idx1_q <= best_idx_d;
                    idx2_q <= sec_idx_d;
                end else if (best_vld_d) begin
                    idx1_q <= best_idx_d;
                end
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign add_begin  = (state_q == EMIT) && pair_q;
    assign last_node  = (state_q == EMIT) && !pair_q;
    assign ADD_1      = add1_q;
    assign ADD_2      = add2_q;
    assign idx1       = idx1_q;
    assign idx2       = idx2_q;
    assign active_cnt = cnt_q;
endmodule

// File: tb/tb_huffman_min2_select.sv
// Directed bench for huffman_min2_select with hand-computed expectations.
module tb_huffman_min2_select;
    localparam int N  = 16;
    localparam int W  = 8;
    localparam int IW = 4;

    logic          CLK = 1'b0;
    logic          nRST, load_en, clear, start, merge_we;
    logic [IW-1:0] load_idx;
    logic [W-1:0]  load_weight, merge_sum;
    logic          busy, add_begin, last_node;
    logic [W-1:0]  ADD_1, ADD_2;
    logic [IW-1:0] idx1, idx2;
    logic [IW:0]   active_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    huffman_min2_select #(.N(N), .W(W), .IW(IW)) dut (
        .CLK(CLK), .nRST(nRST), .load_en(load_en), .load_idx(load_idx),
        .load_weight(load_weight), .clear(clear), .start(start), .busy(busy),
        .ADD_1(ADD_1), .ADD_2(ADD_2), .idx1(idx1), .idx2(idx2),
        .add_begin(add_begin), .merge_we(merge_we), .merge_sum(merge_sum),
        .last_node(last_node), .active_cnt(active_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input int idx, input int w);
        load_en = 1'b1; load_idx = IW'(idx); load_weight = W'(w);
        tick();
        load_en = 1'b0;
    endtask

    // Leaves the bench in cycle t+N+1 (EMIT / last_node cycle).
    task automatic scan();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_rise", busy, 1);
        repeat (N - 1) tick();
        chk("no_early_add", add_begin, 0);
        chk("no_early_last", last_node, 0);
        tick();
    endtask

    task automatic pair(input string tag, input int a1, input int i1, input int a2, input int i2);
        chk({tag, "_add_begin"}, add_begin, 1);
        chk({tag, "_last_node"}, last_node, 0);
        chk({tag, "_ADD_1"}, ADD_1, a1);
        chk({tag, "_idx1"}, idx1, i1);
        chk({tag, "_ADD_2"}, ADD_2, a2);
        chk({tag, "_idx2"}, idx2, i2);
    endtask

    task automatic merge(input string tag, input int sum, input int cnt);
        tick();
        chk({tag, "_pulse_end"}, add_begin, 0);
        merge_we = 1'b1; merge_sum = W'(sum);
        tick();
        merge_we = 1'b0;
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_cnt"}, active_cnt, cnt);
    endtask

    initial begin
        nRST = 1'b0; load_en = 1'b0; clear = 1'b0; start = 1'b0; merge_we = 1'b0;
        load_idx = '0; load_weight = '0; merge_sum = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_add_begin", add_begin, 0);
        chk("rst_last_node", last_node, 0);
        chk("rst_ADD_1", ADD_1, 0);
        chk("rst_idx1", idx1, 0);
        chk("rst_cnt", active_cnt, 0);
        nRST = 1'b1;

        // Full Huffman loop on {5,9,12,13,16,45}
        load(0, 5); load(1, 9); load(2, 12); load(3, 13); load(4, 16); load(5, 45);
        chk("load_cnt", active_cnt, 6);
        scan(); pair("r1", 5, 0, 9, 1); merge("r1", 14, 5);

        scan(); pair("r2", 12, 2, 13, 3);
        merge_we = 1'b1; merge_sum = 8'd0;
        tick();
        merge_we = 1'b0;
        chk("emit_merge_ignored_busy", busy, 1);
        chk("emit_merge_ignored_cnt", active_cnt, 5);
        start = 1'b1; clear = 1'b1; load_en = 1'b1; load_idx = 4'd10; load_weight = 8'd1;
        tick();
        start = 1'b0; clear = 1'b0; load_en = 1'b0;
        chk("wait_drop_busy", busy, 1);
        chk("wait_drop_cnt", active_cnt, 5);
        merge_we = 1'b1; merge_sum = 8'd25;
        tick();
        merge_we = 1'b0;
        chk("r2_idle", busy, 0);
        chk("r2_cnt", active_cnt, 4);

        scan(); pair("r3", 14, 0, 16, 4);  merge("r3", 30, 3);
        scan(); pair("r4", 25, 2, 30, 0);  merge("r4", 55, 2);
        scan(); pair("r5", 45, 5, 55, 2);  merge("r5", 100, 1);
        scan();
        chk("r6_last_node", last_node, 1);
        chk("r6_add_begin", add_begin, 0);
        chk("r6_idx1", idx1, 5);
        chk("r6_ADD_1_held", ADD_1, 45);
        tick();
        chk("r6_idle", busy, 0);
        chk("r6_last_end", last_node, 0);
        load(9, 101);
        scan(); pair("root", 100, 5, 101, 9); merge("root", 201, 1);

        // Tie-break toward lower slot
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_cnt", active_cnt, 0);
        load(2, 4); load(7, 4); load(3, 4);
        scan(); pair("tie", 4, 2, 4, 3); merge("tie", 8, 2);

        // Single active slot
        clear = 1'b1; tick(); clear = 1'b0;
        load(4, 100);
        scan();
        chk("single_last_node", last_node, 1);
        chk("single_add_begin", add_begin, 0);
        chk("single_idx1", idx1, 4);
        chk("single_ADD_1_held", ADD_1, 4);
        chk("single_idx2_held", idx2, 3);
        tick();
        chk("single_idle", busy, 0);

        // Reset in the middle of a scan
        load(1, 7);
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        chk("midscan_busy", busy, 1);
        nRST = 1'b0; tick(); nRST = 1'b1;
        chk("mrst_busy", busy, 0);
        chk("mrst_ADD_1", ADD_1, 0);
        chk("mrst_ADD_2", ADD_2, 0);
        chk("mrst_idx1", idx1, 0);
        chk("mrst_idx2", idx2, 0);
        chk("mrst_cnt", active_cnt, 0);
        scan();
        chk("mrst_last_node", last_node, 1);
        chk("mrst_add_begin", add_begin, 0);
        chk("mrst_idx1_after", idx1, 0);
        tick();

        // Clear+load in one cycle, reload, zero weight in top slot
        clear = 1'b1; load_en = 1'b1; load_idx = 4'd6; load_weight = 8'd30;
        tick();
        clear = 1'b0; load_en = 1'b0;
        chk("clrload_cnt", active_cnt, 1);
        load(6, 20);
        chk("reload_cnt", active_cnt, 1);
        load(15, 0);
        chk("zero_cnt", active_cnt, 2);
        scan(); pair("zero", 0, 15, 20, 6); merge("zero", 20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/huffman_min2_select.md
# huffman_min2_select

Upstream stage of the Huffman tree adder: holds the live node-weight table and scans it for the two smallest active weights. It presents them to the adder as one `add_begin` pulse with `ADD_1`/`ADD_2`. It then accepts the merged sum back and updates the table: the sum replaces the smaller node, and the other node is retired. The tree controller repeats start/merge rounds until `last_node` is reported.

## Interface
Parameters:
- `N`, 16: number of table slots (leaf symbols); must be ≥ 2.
- `W`, 8: weight width, unsigned.
- `IW`, $clog2(N): index width.

Ports:
- `CLK`, in, 1: clock; all logic on the rising edge.
- `nRST`, in, 1: reset, synchronous and active-low.
- `load_en`, in, 1: write `load_weight` into slot `load_idx` and mark it active. Honoured in IDLE only; ignored otherwise.
- `load_idx`, in, IW: slot index; values ≥ N are ignored.
- `load_weight`, in, W: leaf weight. A weight of 0 is legal and is treated as an active node.
- `clear`, in, 1: in IDLE, marks all slots inactive.
- `start`, in, 1: begin one scan round. Honoured in IDLE only.
- `busy`, out, 1: high in any state other than IDLE.
- `ADD_1`, out, W: smallest active weight (MIN1).
- `ADD_2`, out, W: second-smallest active weight (MIN2).
- `idx1`, out, IW: slot index of MIN1.
- `idx2`, out, IW: slot index of MIN2.
- `add_begin`, out, 1: one-cycle pulse; `ADD_1`/`ADD_2` are valid while it is high.
- `merge_we`, in, 1: merge write-back strobe. Honoured in WAIT only.
- `merge_sum`, in, W: adder result, already clamped by the adder.
- `last_node`, out, 1: one-cycle pulse; fewer than 2 active slots were found, so no pair is issued.
- `active_cnt`, out, IW+1: number of active slots.

## Operation
- Internal state: `weight[N]`, `valid[N]`, plus running best/second registers.
- FSM states:
  - IDLE: honour `load_en`, `clear` and `start`. If both `clear` and `load_en` are high in the same cycle, `clear` is applied first and then the load.
  - SCAN: one slot per cycle, index 0 to N-1.
  - EMIT: one cycle.
  - WAIT: hold until `merge_we`.
- Scan comparison, for an active slot with weight w:
  - If w < best: the old best moves to second, and w becomes best.
  - Else if w < second (or second is empty): w becomes second.
  - Comparison is strict, so on equal weights the lower index wins. Both best and second therefore resolve ties toward the lower slot.
- After the last slot is scanned:
  - If ≥ 2 active slots were found: go to EMIT, assert `add_begin`, drive `ADD_1`/`ADD_2`/`idx1`/`idx2`, then go to WAIT.
  - If fewer than 2 were found: pulse `last_node` and return to IDLE. `ADD_*` and `idx*` keep their previous values; with exactly 1 active slot, `idx1` is updated to that slot.
- WAIT with `merge_we`:
  - `weight[idx1] <= merge_sum`.
  - `valid[idx2] <= 0`.
  - `active_cnt` decrements by 1.
  - Return to IDLE.
- `ADD_*` and `idx*` are registered and hold their values until the next EMIT.
- Reset (`nRST` low at a clock edge), including mid-scan or during WAIT:
  - State becomes IDLE.
  - All valid bits cleared; `active_cnt` = 0.
  - `ADD_1`, `ADD_2`, `idx1`, `idx2` = 0.
  - `add_begin`, `last_node`, `busy` = 0.
  - Weight contents are don't-care.
- `active_cnt` changes by +1 on a load into an inactive slot. A reload of an already-active slot overwrites its weight and leaves the count unchanged.

## Timing
- `start` sampled at edge t:
  - SCAN occupies cycles t+1 through t+N.
  - EMIT (`add_begin` high) is cycle t+N+1.
  - `last_node`, when issued, is also high in cycle t+N+1.
- Scan-to-pair latency is N+1 cycles from the `start` edge.
- `busy` rises in the cycle after the `start` edge. It falls in the cycle after the `merge_we` edge, or after the `last_node` cycle.
- `merge_we` arriving at the EMIT cycle itself is ignored. Consumers must wait for the adder, which registers its result, so the earliest useful merge is EMIT+1.
- `start`, `load_en` and `clear` while `busy` are dropped and have no side effects.
- A new round may start in the first IDLE cycle after a merge.

## Structure
- Shared package `huffman_pkg`:
  - `W`, `N`, `IW` defaults.
  - FSM state enum `{IDLE, SCAN, EMIT, WAIT}`.
  - A `node_t` struct `{valid, weight}` for the table entry.
- One natural sub-module, `min2_track`, holds the combinational best/second update. It takes the current best/second value plus index and a candidate, and returns the new pair. It is reusable for a later parallel-tree version.
- Expected size: about 200 RTL lines total.

## Test plan
- Load weights {5,9,12,13,16,45} into slots 0–5, then `start`:
  - `add_begin` at t+17.
  - `ADD_1`=5, `idx1`=0, `ADD_2`=9, `idx2`=1.
  - After `merge_we` with sum 14: slot 0 = 14, slot 1 inactive, `active_cnt` 6→5.
- Tie-break: slots 2, 7 and 3 loaded with weights 4, 4 and 4 (slot 2 = 4, slot 7 = 4, slot 3 = 4) -> `idx1`=2, `idx2`=3.
- Single active slot (slot 4, weight 100) -> `last_node` pulse at t+17, no `add_begin`, `idx1`=4, then back in IDLE.
- Full Huffman loop on 6 leaves: 5 rounds each emit a pair. Round 6 gives `last_node` with the root weight equal to 100 in `idx1`'s slot.
- Pull `nRST` low mid-SCAN (cycle t+5) -> next cycle in IDLE with all outputs 0 and `active_cnt`=0. A subsequent `start` gives `last_node` at t'+N+1.
- `start`/`load_en`/`clear` asserted during WAIT have no effect on the table or the FSM. `merge_we` in EMIT is ignored, and a later `merge_we` completes the round normally.
